// File: rtl/sqrt_sequencer.sv
// sqrt_sequencer
// Sequencing controller for the iterative square-root datapath. Owns the
// 4-bit state register Q that the downstream output decoder turns into
// register enables, bus selects and AU selects. A run is LOAD, INIT, then
// N_ITER iterations of SHIFT/TRIAL/CMP/(SUB|KEEP)/CNT, then a one-cycle DONE.
//
// Ports
//   clk     in   rising-edge system clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request a new computation (sampled only in IDLE)
//   abort   in   synchronous cancel, honoured in LOAD..CNT
//   ge      in   AU flag: partial remainder >= trial value (sampled in CMP)
//   Q       out  registered state code to the output decoder
//   busy    out  Q != IDLE
//   done    out  Q == DONE, one cycle per completed run
//   iter    out  current iteration index 0..N_ITER-1
//   ge_lat  out  ge captured in CMP (current root bit)
//   err     out  sticky illegal-state flag, cleared by the next accepted start

module sqrt_sequencer #(
  parameter int N_ITER = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       ge,
  output logic [3:0] Q,
  output logic       busy,
  output logic       done,
  output logic [3:0] iter,
  output logic       ge_lat,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0000,
    LOAD  = 4'b0001,
    INIT  = 4'b0010,
    SHIFT = 4'b0011,
    TRIAL = 4'b0100,
    CMP   = 4'b0101,
    SUB   = 4'b0110,
    KEEP  = 4'b0111,
    CNT   = 4'b1000,
    DONE  = 4'b1101
  } state_t;

  localparam logic [3:0] LAST = 4'(N_ITER - 1);

  logic [3:0] q_nxt;
  logic [3:0] iter_nxt;
  logic       ge_lat_nxt;
  logic       err_nxt;
  logic       in_run;

  // States in which abort is honoured (LOAD through CNT are contiguous codes).
  assign in_run = (Q >= LOAD) && (Q <= CNT);

  // NOTE: every variable gets its hold value before the case statement, so a
  // path that does not assign it cannot infer a latch.
  always_comb begin
    q_nxt      = Q;
    iter_nxt   = iter;
    ge_lat_nxt = ge_lat;
    err_nxt    = err;

    case (Q)
      IDLE: begin
        if (start) begin
          q_nxt   = LOAD;
          err_nxt = 1'b0;
        end
      end
      LOAD: begin
        q_nxt    = INIT;
        iter_nxt = '0;
      end
      INIT:  q_nxt = SHIFT;
      SHIFT: q_nxt = TRIAL;
      TRIAL: q_nxt = CMP;
      CMP: begin
        q_nxt      = ge ? SUB : KEEP;
        ge_lat_nxt = ge;
      end
      SUB, KEEP: q_nxt = CNT;
      CNT: begin
        if (iter < LAST) begin
          q_nxt    = SHIFT;
          iter_nxt = iter + 4'd1;
        end else begin
          q_nxt = DONE;
        end
      end
      DONE: q_nxt = IDLE;
      default: begin
        // Unreachable codes recover to IDLE and leave a sticky marker.
        q_nxt   = IDLE;
        err_nxt = 1'b1;
      end
    endcase

    // Abort cancels the run without touching the iteration index or root bit.
    if (abort && in_run) begin
      q_nxt      = IDLE;
      iter_nxt   = iter;
      ge_lat_nxt = ge_lat;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q      <= IDLE;
      iter   <= '0;
      ge_lat <= 1'b0;
      err    <= 1'b0;
    end else begin
      Q      <= q_nxt;
      iter   <= iter_nxt;
      ge_lat <= ge_lat_nxt;
      err    <= err_nxt;
    end
  end

  assign busy = (Q != IDLE);
  assign done = (Q == DONE);

endmodule

// File: tb/tb_sqrt_sequencer.sv
// Self-checking bench for sqrt_sequencer. A run-position model (offset from
// the accepted start) predicts every output each cycle; directed scenarios
// pin cycle counts and the root-bit choices with literal values.

module tb_sqrt_sequencer;

  localparam int N  = 8;
  localparam int PD = 2 + 5 * N;  // run position of DONE

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ge = 1'b0;
  logic [3:0] q, iter;
  logic       busy, done, ge_lat, err;

  logic       start1 = 1'b0;
  logic       ge1 = 1'b0;
  logic [3:0] q1, iter1;
  logic       busy1, done1, ge_lat1, err1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sqrt_sequencer #(.N_ITER(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ge(ge),
    .Q(q), .busy(busy), .done(done), .iter(iter), .ge_lat(ge_lat), .err(err)
  );

  sqrt_sequencer #(.N_ITER(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .ge(ge1),
    .Q(q1), .busy(busy1), .done(done1), .iter(iter1), .ge_lat(ge_lat1), .err(err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: position within the current run -------
  bit         m_run;
  int         m_p;
  bit         m_sub;
  logic [3:0] m_iter;
  logic       m_gl, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_p <= 0; m_sub <= 1'b0;
      m_iter <= '0; m_gl <= 1'b0; m_err <= 1'b0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1'b1; m_p <= 0; m_err <= 1'b0;
      end
    end else if (m_p == PD) begin
      m_run <= 1'b0;
    end else if (abort) begin
      m_run <= 1'b0;
    end else begin
      if (m_p == 0) m_iter <= '0;
      else if (m_p >= 2) begin
        if ((m_p - 2) % 5 == 2) begin
          m_gl <= ge; m_sub <= ge;
        end
        if ((m_p - 2) % 5 == 4 && (m_p - 2) / 5 < N - 1)
          m_iter <= 4'((m_p - 2) / 5 + 1);
      end
      m_p <= m_p + 1;
    end
  end

  function automatic logic [3:0] exp_q();
    if (!m_run)       return 4'd0;
    if (m_p == 0)     return 4'd1;
    if (m_p == 1)     return 4'd2;
    if (m_p == PD)    return 4'd13;
    case ((m_p - 2) % 5)
      0:       return 4'd3;
      1:       return 4'd4;
      2:       return 4'd5;
      3:       return m_sub ? 4'd6 : 4'd7;
      default: return 4'd8;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("q",      q,      exp_q());
      check("busy",   busy,   m_run);
      check("done",   done,   m_run && m_p == PD);
      check("iter",   iter,   m_iter);
      check("ge_lat", ge_lat, m_gl);
      check("err",    err,    m_err);
    end
  end

  // ---------------- directed + random stimulus ------------------------------
  logic [7:0] pat = 8'h4D;  // ge per iteration, bit i = iteration i: 1,0,1,1,0,0,1,0
  logic [7:0] sub_bits, gl_bits;
  int done_at, done_cnt, mdone_at, loads, second;

  task automatic wait_idle();
    for (int i = 0; i < 100 && q != 4'd0; i++) @(negedge clk);
    check("idle_reached", q, 0);
  endtask

  initial begin
    #2;
    check("rst_q", q, 0);     check("rst_busy", busy, 0); check("rst_done", done, 0);
    check("rst_iter", iter, 0); check("rst_ge_lat", ge_lat, 0); check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Normal run with the fixed root-bit pattern.
    sub_bits = '0; gl_bits = '0; done_at = 0; done_cnt = 0; mdone_at = 0;
    start = 1'b1;
    for (int n = 1; n <= 46; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done) begin done_cnt++; if (done_at == 0) done_at = n; end
      if (m_run && m_p == PD && mdone_at == 0) mdone_at = n;
      if (n >= 3 && n <= PD) begin
        if ((n - 3) % 5 == 3) sub_bits[(n - 3) / 5] = (q == 4'd6);
        if ((n - 3) % 5 == 4) gl_bits[(n - 3) / 5] = ge_lat;
      end
      ge = (n >= 3 && n <= PD && (n - 3) % 5 == 2) ? pat[(n - 3) / 5]
                                                   : 1'($urandom_range(0, 1));
    end
    check("done_cycle", done_at, 43);
    check("model_done_cycle", mdone_at, 43);
    check("done_width", done_cnt, 1);
    check("sub_keep_bits", sub_bits, 8'h4D);
    check("ge_lat_bits", gl_bits, 8'h4D);
    wait_idle();

    // start held high: second LOAD 44 cycles after the first.
    loads = 0; second = 0;
    start = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      ge = 1'($urandom_range(0, 1));
      if (q == 4'd1) begin loads++; if (loads == 2) second = n; end
    end
    start = 1'b0;
    check("b2b_second_load", second, 45);
    wait_idle();

    // start pulsed while busy (including in DONE) is ignored.
    loads = 0;
    start = 1'b1;
    for (int n = 1; n <= 46; n++) begin
      @(negedge clk);
      if (q == 4'd1) loads++;
      ge = 1'($urandom_range(0, 1));
      start = (n == 43) ? 1'b1 : (n >= 4 && n <= 42) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    check("busy_start_loads", loads, 1);
    wait_idle();

    // Abort in TRIAL of iteration 3.
    done_cnt = 0;
    start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done) done_cnt++;
      abort = 1'b0;
      if (n == 19) begin
        check("abort_at_trial_q", q, 4);
        abort = 1'b1;
      end else if (n == 20) begin
        check("abort_q", q, 0);
        check("abort_iter", iter, 3);
      end
    end
    check("abort_no_done", done_cnt, 0);

    // Abort in DONE is ignored.
    start = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      abort = 1'b0;
      if (n == 43) begin
        check("abort_done_seen", done, 1);
        abort = 1'b1;
      end else if (n == 44) begin
        check("abort_done_then_idle", q, 0);
      end
    end

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 15) == 0);
      abort = ($urandom_range(0, 59) == 0);
      ge    = 1'($urandom_range(0, 1));
    end
    start = 1'b0; abort = 1'b0;
    wait_idle();

    // Asynchronous reset in CMP.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && q != 4'd5; i++) @(negedge clk);
    check("reached_cmp", q, 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", q, 0);       check("arst_busy", busy, 0); check("arst_done", done, 0);
    check("arst_iter", iter, 0); check("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("arst_no_done", done_cnt, 0);

    // N_ITER = 1 instance.
    done_at = 0;
    start1 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) start1 = 1'b0;
      ge1 = 1'($urandom_range(0, 1));
      if (done1 && done_at == 0) done_at = n;
    end
    check("n1_done_cycle", done_at, 8);

    // Illegal state recovery.
    chk_en = 1'b0;
    @(negedge clk);
    force u_dut.Q = 4'hF;
    @(negedge clk);
    release u_dut.Q;
    @(negedge clk);
    check("illegal_q", q, 0);
    check("illegal_err", err, 1);
    repeat (3) @(negedge clk);
    check("illegal_err_held", err, 1);
    check("illegal_idle_held", q, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_q", q, 1);
    check("restart_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
